// File: rtl/pipeline_register_fetch_decode_elastic_pkg.sv
// Shared types and field geometry for the fetch/decode elastic pipeline register.
// The payload struct carries the instruction together with its pre-sliced fields.
package pipeline_pkg;

  localparam int FD_INSTR_W = 18;
  localparam int FD_PC_W    = 16;
  localparam int FD_OPC_W   = 6;
  localparam int FD_REG_W   = 4;
  localparam int FD_IMM_W   = 4;
  localparam int FD_JMP_W   = 12;
  localparam int FD_HIST_W  = 3;
  localparam int FD_PERF_W  = 16;

  // Field offsets: opcode sits at the top, then addr1 and addr2 directly below it.
  localparam int FD_OPC_LSB   = FD_INSTR_W - FD_OPC_W;
  localparam int FD_ADDR1_LSB = FD_OPC_LSB - FD_REG_W;
  localparam int FD_ADDR2_LSB = FD_ADDR1_LSB - FD_REG_W;

  typedef struct packed {
    logic [FD_INSTR_W-1:0] instruction;
    logic [FD_OPC_W-1:0]   opcode;
    logic [FD_REG_W-1:0]   addr1;
    logic [FD_REG_W-1:0]   addr2;
    logic [FD_IMM_W-1:0]   imm;
    logic [FD_JMP_W-1:0]   jump;
    logic [FD_PC_W-1:0]    pc;
    logic [FD_PC_W-1:0]    pc_inc;
    logic [FD_HIST_W-1:0]  hist;
  } fd_payload_t;

  // Encoding equals the number of entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fd_state_t;

  typedef enum logic [1:0] {
    HEAD_HOLD,
    HEAD_IN,
    HEAD_SKID,
    HEAD_CLR
  } head_src_t;

endpackage

// File: rtl/pipeline_register_fetch_decode_elastic_if.sv
// Fetch-side and decode-side handshake bundle of the elastic fetch/decode register.
// master drives fetch data and decode ready; slave is the buffer itself.
interface pipeline_register_fetch_decode_elastic_if;
  import pipeline_pkg::*;

  logic                  f_valid;
  logic                  f_ready;
  logic [FD_INSTR_W-1:0] f_instruction;
  logic [FD_PC_W-1:0]    f_pc;
  logic [FD_PC_W-1:0]    f_pc_inc;
  logic [FD_HIST_W-1:0]  f_hist;

  logic                  d_valid;
  logic                  d_ready;
  logic [FD_INSTR_W-1:0] d_instruction;
  logic [FD_OPC_W-1:0]   d_opcode;
  logic [FD_REG_W-1:0]   d_addr1;
  logic [FD_REG_W-1:0]   d_addr2;
  logic [FD_IMM_W-1:0]   d_imm;
  logic [FD_JMP_W-1:0]   d_jump;
  logic [FD_PC_W-1:0]    d_pc;
  logic [FD_PC_W-1:0]    d_pc_inc;
  logic [FD_HIST_W-1:0]  d_hist;

  modport master (
    output f_valid, f_instruction, f_pc, f_pc_inc, f_hist, d_ready,
    input  f_ready, d_valid, d_instruction, d_opcode, d_addr1, d_addr2,
           d_imm, d_jump, d_pc, d_pc_inc, d_hist
  );

  modport slave (
    input  f_valid, f_instruction, f_pc, f_pc_inc, f_hist, d_ready,
    output f_ready, d_valid, d_instruction, d_opcode, d_addr1, d_addr2,
           d_imm, d_jump, d_pc, d_pc_inc, d_hist
  );

endinterface

// File: rtl/pipeline_register_fetch_decode_elastic_slicer.sv
// Combinational instruction slicer on the capture path: splits the raw
// instruction into the fields that decode consumes.
module fd_instr_slicer
  import pipeline_pkg::*;
(
  input  logic [FD_INSTR_W-1:0] instruction,
  output logic [FD_OPC_W-1:0]   opcode,
  output logic [FD_REG_W-1:0]   addr1,
  output logic [FD_REG_W-1:0]   addr2,
  output logic [FD_IMM_W-1:0]   imm,
  output logic [FD_JMP_W-1:0]   jump
);

  assign opcode = instruction[FD_OPC_LSB   +: FD_OPC_W];
  assign addr1  = instruction[FD_ADDR1_LSB +: FD_REG_W];
  assign addr2  = instruction[FD_ADDR2_LSB +: FD_REG_W];
  assign imm    = instruction[FD_IMM_W-1:0];
  assign jump   = instruction[FD_JMP_W-1:0];

endmodule

// File: rtl/pipeline_register_fetch_decode_elastic.sv
// Two-entry elastic (skid) register between fetch and decode, with flush and
// a saturating backpressure counter. f_ready depends on registered state only.
module pipeline_register_fetch_decode_elastic
  import pipeline_pkg::*;
#(
  parameter int INSTR_W = FD_INSTR_W,
  parameter int PC_W    = FD_PC_W,
  parameter int OPC_W   = FD_OPC_W,
  parameter int REG_W   = FD_REG_W,
  parameter int IMM_W   = FD_IMM_W,
  parameter int JMP_W   = FD_JMP_W,
  parameter int HIST_W  = FD_HIST_W,
  parameter int PERF_W  = FD_PERF_W
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   perf_clr,
  pipeline_register_fetch_decode_elastic_if.slave bus,
  output logic [1:0]                             occupancy,
  output logic [PERF_W-1:0]                      stall_cnt
);

  if (OPC_W + 2*REG_W + IMM_W != INSTR_W || JMP_W > INSTR_W - OPC_W) begin : g_bad_fields
    $error("instruction fields do not partition INSTR_W");
  end
  if (INSTR_W != FD_INSTR_W || PC_W != FD_PC_W || OPC_W != FD_OPC_W || REG_W != FD_REG_W ||
      IMM_W != FD_IMM_W || JMP_W != FD_JMP_W || HIST_W != FD_HIST_W) begin : g_bad_pkg
    $error("payload widths must match pipeline_pkg");
  end

  fd_state_t   state, state_next;
  head_src_t   head_src;
  logic        skid_load;
  fd_payload_t head, skid, captured;
  logic        accept, drain;

  logic [FD_OPC_W-1:0] s_opcode;
  logic [FD_REG_W-1:0] s_addr1, s_addr2;
  logic [FD_IMM_W-1:0] s_imm;
  logic [FD_JMP_W-1:0] s_jump;

  fd_instr_slicer u_slicer (
    .instruction (bus.f_instruction),
    .opcode      (s_opcode),
    .addr1       (s_addr1),
    .addr2       (s_addr2),
    .imm         (s_imm),
    .jump        (s_jump)
  );

  assign captured = '{instruction: bus.f_instruction, opcode: s_opcode, addr1: s_addr1,
                      addr2: s_addr2, imm: s_imm, jump: s_jump, pc: bus.f_pc,
                      pc_inc: bus.f_pc_inc, hist: bus.f_hist};

  assign bus.f_ready = (state != FULL);
  assign bus.d_valid = (state != EMPTY);
  assign occupancy   = state;
  assign accept      = bus.f_valid & bus.f_ready;
  assign drain       = bus.d_valid & bus.d_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    head_src   = HEAD_HOLD;
    skid_load  = 1'b0;
    unique case (state)
      EMPTY: if (accept) begin
        state_next = ONE;
        head_src   = HEAD_IN;
      end
      ONE: begin
        if (accept && drain) begin
          head_src = HEAD_IN;
        end else if (accept) begin
          skid_load  = 1'b1;
          state_next = FULL;
        end else if (drain) begin
          head_src   = HEAD_CLR;
          state_next = EMPTY;
        end
      end
      FULL: if (drain) begin
        head_src   = HEAD_SKID;
        state_next = ONE;
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next = EMPTY;
      head_src   = HEAD_CLR;
      skid_load  = 1'b0;
    end
  end

  // Emptied entries are zeroed so the payload outputs read as a NOP bubble
  // straight from the registers whenever d_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the payload registers are reset too, because the zero-bubble output relies on it.
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      case (head_src)
        HEAD_IN:   head <= captured;
        HEAD_SKID: head <= skid;
        HEAD_CLR:  head <= '0;
        default:   head <= head;
      endcase
      if (flush || head_src == HEAD_SKID) skid <= '0;
      else if (skid_load)                 skid <= captured;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         stall_cnt <= '0;
    else if (perf_clr)                                 stall_cnt <= '0;
    else if (bus.d_valid && !bus.d_ready && !flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + PERF_W'(1);
  end

  assign bus.d_instruction = head.instruction;
  assign bus.d_opcode      = head.opcode;
  assign bus.d_addr1       = head.addr1;
  assign bus.d_addr2       = head.addr2;
  assign bus.d_imm         = head.imm;
  assign bus.d_jump        = head.jump;
  assign bus.d_pc          = head.pc;
  assign bus.d_pc_inc      = head.pc_inc;
  assign bus.d_hist        = head.hist;

endmodule
